// File: rtl/prim_clock_mux_ctrl_pkg.sv
// Shared types and widths for the 2:1 clock-mux select controller.
package prim_clock_mux_ctrl_pkg;

    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_OFF = 2'd1,
        SWITCH   = 2'd2,
        DONE     = 2'd3
    } mux_ctrl_state_e;

endpackage

// File: rtl/prim_clock_mux_ctrl_cnt.sv
// Loadable down-counter that times the gate-off and settle windows.
module prim_clock_mux_ctrl_cnt
    import prim_clock_mux_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [CntW-1:0] load_val,
    input  logic            dec,
    output logic            zero
);

    logic [CntW-1:0] cnt;

    // Load wins over decrement; saturate at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CntW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/prim_clock_mux_sel_ctrl.sv
// Clock-mux select controller: gates the downstream clock off, flips the
// mux select, lets it settle, re-enables the gate and acks the requester.
module prim_clock_mux_sel_ctrl
    import prim_clock_mux_ctrl_pkg::*;
#(
    parameter int unsigned GateOffCycles = 2,
    parameter int unsigned SettleCycles  = 4,
    parameter logic        InitSel       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_valid_i,
    input  logic req_sel_i,
    output logic req_ready_o,
    output logic ack_o,
    output logic sel_o,
    output logic gate_en_o,
    output logic busy_o
);

    if ((GateOffCycles < 1) || (GateOffCycles > 15)) begin : g_bad_gate_off
        $error("GateOffCycles must be in 1..15");
    end
    if ((SettleCycles < 1) || (SettleCycles > 15)) begin : g_bad_settle
        $error("SettleCycles must be in 1..15");
    end

    mux_ctrl_state_e state;
    logic            sel_q;
    logic            gate_q;
    logic            ack_q;
    logic            busy_q;
    logic            ready_q;
    logic            tgt;
    logic            accept;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_zero;
    logic [CntW-1:0] cnt_load_val;

    assign accept = req_valid_i & ready_q;

    // Counter control: arm the gate-off window on a real switch, then the settle window.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        case (state)
            IDLE: begin
                if (accept && (req_sel_i != sel_q)) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CntW'(GateOffCycles - 1);
                end
            end
            GATE_OFF: begin
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CntW'(SettleCycles - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SWITCH: begin
                cnt_dec = ~cnt_zero;
            end
            default: ;
        endcase
    end

    prim_clock_mux_ctrl_cnt u_cnt (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            sel_q   <= InitSel;
            gate_q  <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            tgt     <= InitSel;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tgt     <= req_sel_i;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        // Same select needs no gating: ack straight away.
                        if (req_sel_i == sel_q) begin
                            state <= DONE;
                            ack_q <= 1'b1;
                        end else begin
                            state  <= GATE_OFF;
                            gate_q <= 1'b0;
                        end
                    end
                end
                GATE_OFF: begin
                    if (cnt_zero) begin
                        sel_q <= tgt;
                        state <= SWITCH;
                    end
                end
                SWITCH: begin
                    if (cnt_zero) begin
                        gate_q <= 1'b1;
                        ack_q  <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = ready_q & ~rst_i;
    assign ack_o       = ack_q;
    assign sel_o       = sel_q;
    assign gate_en_o   = gate_q;
    assign busy_o      = busy_q;

    a_known: assert property (@(posedge clk_i) disable iff (rst_i)
        !$isunknown(sel_o) && !$isunknown(gate_en_o));

    a_ack_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
        $past(ack_o) |-> !ack_o);

    a_sel_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (gate_en_o && !$past(rst_i)) |-> $stable(sel_o));

endmodule
